// File: rtl/avst_field_filter_if.sv
// avst_field_filter_if
//   One Avalon-ST stream: data, valid, ready, startofpacket, endofpacket.
//   master : drives data/valid/startofpacket/endofpacket, receives ready
//   slave  : receives data/valid/startofpacket/endofpacket, drives ready
interface avst_field_filter_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;
   logic                  startofpacket;
   logic                  endofpacket;

   modport master (output data, valid, startofpacket, endofpacket, input ready);
   modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/avst_field_filter.sv
// avst_field_filter
//   Sits in front of a deinterlacer. Control packets are buffered so that the
//   field type in beat 9 can be examined before anything is emitted. F1 fields
//   (control packet plus the following video packets) are discarded; F0,
//   progressive and ancillary packets are forwarded. Video packets are
//   length-checked against one field of WIDTH x HEIGHT/2 pixels plus header.
// Ports
//   clock, reset    : sole clock, asynchronous active-high reset
//   din             : Avalon-ST video sink (interlaced fields)
//   dout            : Avalon-ST source towards the deinterlacer (one register stage)
//   fields_kept     : wrapping count of forwarded F0/progressive video packets
//   fields_dropped  : wrapping count of discarded F1 video packets
//   len_err         : sticky video packet length mismatch flag
module avst_field_filter #(
   parameter int SYMBOLS_PER_BEAT = 1,
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int WIDTH            = 640,
   parameter int HEIGHT           = 480
) (
   input  logic                clock,
   input  logic                reset,
   avst_field_filter_if.slave  din,
   avst_field_filter_if.master dout,
   output logic [15:0]         fields_kept,
   output logic [15:0]         fields_dropped,
   output logic                len_err
);
   localparam int          DATA_WIDTH = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;
   localparam logic [19:0] N_BEATS    = 20'(1 + (WIDTH * HEIGHT) / 2);

   typedef enum logic [2:0] {IDLE, CTRL_CAPTURE, CTRL_EMIT, PASS, DROP} state_t;
   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] cap_buf [10];
   logic [3:0]            cap_cnt;
   logic                  cap_eop;
   logic [3:0]            emit_idx;
   logic [19:0]           beat_cnt;
   logic                  vid_pkt;     // current packet is video and still counted
   logic                  drop_flag;
   logic                  ready_en;    // holds din.ready low until the first edge after reset
   logic                  out_valid, out_sop, out_eop;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  rdy;

   logic       out_free, accept, idle_sop, is_ctrl, is_video, drop_start;
   logic       cap_beat, cap_end, cap_f1, fwd_beat, fwd_eop, vid_beat, vid_end;
   logic       len_bad, force_cut, emit_fire, emit_last;
   logic [3:0] cap_pos;
   logic [19:0] cnt_now;

   assign out_free   = !out_valid || dout.ready;
   assign accept     = din.valid && rdy;
   assign idle_sop   = (state == IDLE) && accept && din.startofpacket;
   assign is_ctrl    = (din.data[3:0] == 4'hF);
   assign is_video   = (din.data[3:0] == 4'h0);
   assign drop_start = idle_sop && is_video && drop_flag;

   assign cap_beat = accept && ((state == CTRL_CAPTURE) || (idle_sop && is_ctrl));
   assign cap_pos  = (state == CTRL_CAPTURE) ? cap_cnt : 4'd0;
   assign cap_end  = cap_beat && (din.endofpacket || (cap_pos == 4'd9));
   // Beat 9 carries the field type: bit3 = interlaced, bit2 = F1
   assign cap_f1   = (cap_pos == 4'd9) && din.data[3] && din.data[2];

   assign fwd_beat  = accept && ((state == PASS) ||
                      (idle_sop && !is_ctrl && !(is_video && drop_flag)));
   assign vid_beat  = fwd_beat && ((state == IDLE) ? is_video : vid_pkt);
   assign cnt_now   = (state == IDLE) ? 20'd1 : beat_cnt + 20'd1;
   assign fwd_eop   = din.endofpacket || (vid_beat && (cnt_now == N_BEATS));
   assign vid_end   = vid_beat && (din.endofpacket || (cnt_now == N_BEATS));
   assign len_bad   = !(din.endofpacket && (cnt_now == N_BEATS));
   // Full field delivered but no eop yet: truncate here and swallow the rest
   assign force_cut = vid_beat && (cnt_now == N_BEATS) && !din.endofpacket;

   assign emit_fire = (state == CTRL_EMIT) && out_free;
   assign emit_last = (emit_idx == cap_cnt - 4'd1);

   assign din.ready          = rdy;
   assign dout.valid         = out_valid;
   assign dout.data          = out_data;
   assign dout.startofpacket = out_sop;
   assign dout.endofpacket   = out_eop;

   always_comb begin
      rdy = 1'b0;
      if (ready_en) begin
         case (state)
            IDLE, PASS:         rdy = out_free;
            CTRL_CAPTURE, DROP: rdy = 1'b1;
            default:            rdy = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (idle_sop) begin
            if (is_ctrl)         state_nxt = cap_end ? CTRL_EMIT : CTRL_CAPTURE;
            else if (drop_start) state_nxt = din.endofpacket ? IDLE : DROP;
            else if (!fwd_eop)   state_nxt = PASS;
         end
         CTRL_CAPTURE: if (cap_end) begin
            if (cap_f1) state_nxt = din.endofpacket ? IDLE : DROP;
            else        state_nxt = CTRL_EMIT;
         end
         CTRL_EMIT: if (emit_fire && emit_last) state_nxt = cap_eop ? IDLE : PASS;
         PASS:      if (fwd_beat && fwd_eop) state_nxt = force_cut ? DROP : IDLE;
         DROP:      if (accept && din.endofpacket) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (cap_beat) cap_buf[cap_pos] <= din.data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ready_en       <= 1'b0;
         out_valid      <= 1'b0;
         out_sop        <= 1'b0;
         out_eop        <= 1'b0;
         out_data       <= '0;
         cap_cnt        <= 4'd0;
         cap_eop        <= 1'b0;
         emit_idx       <= 4'd0;
         beat_cnt       <= 20'd0;
         vid_pkt        <= 1'b0;
         drop_flag      <= 1'b0;
         fields_kept    <= 16'd0;
         fields_dropped <= 16'd0;
         len_err        <= 1'b0;
      end else begin
         ready_en <= 1'b1;

         if (fwd_beat) begin
            out_valid <= 1'b1;
            out_data  <= din.data;
            out_sop   <= (state == IDLE);
            out_eop   <= fwd_eop;
         end else if (emit_fire) begin
            out_valid <= 1'b1;
            out_data  <= cap_buf[emit_idx];
            out_sop   <= (emit_idx == 4'd0);
            out_eop   <= cap_eop && emit_last;
         end else if (dout.ready) begin
            out_valid <= 1'b0;
         end

         if (cap_beat) begin
            cap_cnt  <= cap_pos + 4'd1;
            emit_idx <= 4'd0;
            if (cap_end) begin
               cap_eop   <= din.endofpacket;
               drop_flag <= cap_f1;
            end
         end
         if (emit_fire) emit_idx <= emit_idx + 4'd1;

         if (fwd_beat) beat_cnt <= cnt_now;
         if (idle_sop) vid_pkt <= is_video;
         if (force_cut) vid_pkt <= 1'b0;

         if (vid_end) fields_kept <= fields_kept + 16'd1;
         if (vid_end && len_bad) len_err <= 1'b1;
         if ((drop_start && din.endofpacket) ||
             ((state == DROP) && accept && din.endofpacket && vid_pkt))
            fields_dropped <= fields_dropped + 16'd1;
      end
   end
endmodule
